// File: rtl/hdr_sched_pkg.sv
// Shared types and command field layout for the HDR command scheduler.
package hdr_sched_pkg;

  localparam int CMD_W        = 9;
  localparam int CMD_TID_MSB  = 8;
  localparam int CMD_TID_LSB  = 5;
  localparam int CMD_CP_BIT   = 4;
  localparam int CMD_TOC_BIT  = 3;
  localparam int CMD_MODE_MSB = 2;
  localparam int CMD_MODE_LSB = 0;

  localparam logic [2:0] MODE_HDR_DDR = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP,
    ST_CHAIN
  } sched_state_t;

endpackage

// File: rtl/hdr_cmd_fifo.sv
// Synchronous descriptor FIFO with combinational read of the head entry.
module hdr_cmd_fifo
  import hdr_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [CMD_W-1:0] push_data,
  input  logic             pop,
  output logic [CMD_W-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [CMD_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_en;
  logic             rd_en;

  // A simultaneous pop frees the slot, so a push while full is accepted then.
  assign wr_en    = push && (!full || pop);
  assign rd_en    = pop && !empty;
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hdr_cmd_scheduler.sv
// Sequences queued HDR descriptors into hdr_engine one at a time.
// Optional per-descriptor abort timer enabled by defining HDR_SCHED_TIMEOUT_EN.
module hdr_cmd_scheduler
  import hdr_sched_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             i_sys_clk,
  input  logic             i_sys_rst,
  input  logic             i_cmd_valid,
  input  logic [CMD_W-1:0] i_cmd_data,
  output logic             o_cmd_ready,
  output logic             o_hdr_en,
  output logic             o_hdr_cp,
  output logic             o_hdr_toc,
  output logic [2:0]       o_hdr_mode,
  input  logic             i_hdr_done,
  output logic             o_rsp_valid,
  output logic [3:0]       o_rsp_tid,
  output logic             o_rsp_err,
  output logic             o_busy
);

  sched_state_t     state;
  sched_state_t     state_next;
  logic [CMD_W-1:0] act;
  logic [CMD_W-1:0] fifo_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             expire;

  assign o_cmd_ready = !fifo_full;
  assign push        = i_cmd_valid && !fifo_full;
  assign pop         = ((state == ST_IDLE) || (state == ST_CHAIN)) && !fifo_empty;

  hdr_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (i_sys_clk),
    .rst       (i_sys_rst),
    .push      (push),
    .push_data (i_cmd_data),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state <= ST_IDLE;
      act   <= '0;
    end else begin
      state <= state_next;
      if (pop) begin
        act <= fifo_data;
      end
    end
  end

`ifdef HDR_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] tmo_cnt;

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      tmo_cnt <= '0;
    end else if (state == ST_ISSUE) begin
      tmo_cnt <= '0;
    end else if (state == ST_WAIT) begin
      tmo_cnt <= tmo_cnt + CW'(1);
    end
  end

  // A done landing on the expiry cycle completes normally instead of aborting.
  assign expire = (state == ST_WAIT) && (tmo_cnt == CW'(TIMEOUT_CYC)) && !i_hdr_done;
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYC;
  assign expire     = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (!fifo_empty) state_next = ST_ISSUE;
      ST_ISSUE: state_next = i_hdr_done ? ST_RESP : ST_WAIT;
      ST_WAIT: begin
        if (i_hdr_done) begin
          state_next = ST_RESP;
        end else if (expire) begin
          state_next = ST_IDLE;
        end
      end
      ST_RESP:  state_next = act[CMD_TOC_BIT] ? ST_IDLE : ST_CHAIN;
      ST_CHAIN: if (!fifo_empty) state_next = ST_ISSUE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Enable stays up through RESP and CHAIN so restart chains never see a gap.
  assign o_hdr_en    = (state != ST_IDLE) && !expire;
  assign o_hdr_cp    = act[CMD_CP_BIT];
  assign o_hdr_toc   = act[CMD_TOC_BIT];
  assign o_hdr_mode  = act[CMD_MODE_MSB:CMD_MODE_LSB];
  assign o_rsp_valid = (state == ST_RESP) || expire;
  assign o_rsp_tid   = act[CMD_TID_MSB:CMD_TID_LSB];
  assign o_rsp_err   = expire;
  assign o_busy      = (state != ST_IDLE) || !fifo_empty;

endmodule
